// File: rtl/ptw_arbiter_if.sv
// Signal bundle between the I/D MMU page-table walkers, the PTW arbiter and the
// Wishbone classic read port it drives.
interface ptw_arbiter_if;
    logic        i_ptw_req;
    logic [31:0] i_ptw_addr;
    logic [31:0] i_ptw_data;
    logic        i_ptw_ack;

    logic        d_ptw_req;
    logic [31:0] d_ptw_addr;
    logic [31:0] d_ptw_data;
    logic        d_ptw_ack;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    // Arbiter side: answers the MMUs, masters the bus.
    modport master (
        input  i_ptw_req, i_ptw_addr, d_ptw_req, d_ptw_addr,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output i_ptw_data, i_ptw_ack, d_ptw_data, d_ptw_ack,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o
    );

    // Environment side: MMU requesters and the bus slave.
    modport slave (
        output i_ptw_req, i_ptw_addr, d_ptw_req, d_ptw_addr,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  i_ptw_data, i_ptw_ack, d_ptw_data, d_ptw_ack,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o
    );
endinterface

// File: rtl/ptw_arbiter.sv
// Round-robin arbiter merging I-side and D-side Sv32 PTW reads onto one Wishbone
// classic read port; one outstanding access, registered responses, bus timeout.
module ptw_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    ptw_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
    localparam bit          TO_EN  = (TIMEOUT != 0);

    state_t      state_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic        cyc_q;
    logic        i_ack_q;
    logic        d_ack_q;
    logic [31:0] adr_q;
    logic [31:0] i_data_q;
    logic [31:0] d_data_q;
    logic [15:0] cnt_q;

    logic        any_req;
    logic        gnt_d;
    logic [31:0] req_adr;
    logic [15:0] cnt_d;
    logic        bus_done;
    logic [31:0] data_d;

    always_comb begin
        any_req  = bus.i_ptw_req | bus.d_ptw_req;
        // D wins when it is alone, or on a tie when I was served last.
        gnt_d    = bus.d_ptw_req & (~bus.i_ptw_req | ~last_grant_q);
        req_adr  = gnt_d ? bus.d_ptw_addr : bus.i_ptw_addr;
        cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        bus_done = bus.wb_err_i | bus.wb_ack_i | (TO_EN && (cnt_d == TO_LIM));
        // Error and timeout both return an all-zero PTE (V=0) so the MMU faults.
        data_d   = (bus.wb_ack_i & ~bus.wb_err_i) ? bus.wb_dat_i : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cyc_q        <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            adr_q        <= 32'h0;
            i_data_q     <= 32'h0;
            d_data_q     <= 32'h0;
            cnt_q        <= 16'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q        <= gnt_d;
                        last_grant_q <= gnt_d;
                        adr_q        <= {req_adr[31:2], 2'b00};
                        cnt_q        <= 16'h0;
                        cyc_q        <= 1'b1;
                        state_q      <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        cyc_q    <= 1'b0;
                        i_ack_q  <= ~gnt_q;
                        d_ack_q  <= gnt_q;
                        i_data_q <= gnt_q ? 32'h0 : data_d;
                        d_data_q <= gnt_q ? data_d : 32'h0;
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    // Requests are not sampled here; the MMU may be swapping its address.
                    i_ack_q  <= 1'b0;
                    d_ack_q  <= 1'b0;
                    i_data_q <= 32'h0;
                    d_data_q <= 32'h0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wb_cyc_o   = cyc_q;
    assign bus.wb_stb_o   = cyc_q;
    assign bus.wb_we_o    = 1'b0;
    assign bus.wb_sel_o   = 4'hF;
    assign bus.wb_adr_o   = adr_q;
    assign bus.i_ptw_ack  = i_ack_q;
    assign bus.d_ptw_ack  = d_ack_q;
    assign bus.i_ptw_data = i_data_q;
    assign bus.d_ptw_data = d_data_q;
endmodule
